// File: rtl/rename_unit_ckpt.sv
// Multi-lane register renamer: bitmask free list, in-group RAW/WAW bypass,
// commit-time release of old mappings and flush recovery from the committed map.
module rename_unit_ckpt #(
    parameter int FETCH_W   = 2,
    parameter int COMMIT_W  = 2,
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 48,
    parameter int PAYLOAD_W = 96,
    localparam int AW = $clog2(ARCH_REGS),
    localparam int PW = $clog2(PHYS_REGS)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [FETCH_W-1:0]           in_valid,
    output logic                         in_ready,
    input  logic [FETCH_W*AW-1:0]        in_rs1,
    input  logic [FETCH_W*AW-1:0]        in_rs2,
    input  logic [FETCH_W-1:0]           in_rs1_valid,
    input  logic [FETCH_W-1:0]           in_rs2_valid,
    input  logic [FETCH_W*AW-1:0]        in_rd,
    input  logic [FETCH_W-1:0]           in_rd_valid,
    input  logic [FETCH_W*PAYLOAD_W-1:0] in_payload,
    output logic [FETCH_W-1:0]           out_valid,
    input  logic                         out_ready,
    output logic [FETCH_W*PW-1:0]        out_prs1,
    output logic [FETCH_W*PW-1:0]        out_prs2,
    output logic [FETCH_W*PW-1:0]        out_prd,
    output logic [FETCH_W*PW-1:0]        out_prd_old,
    output logic [FETCH_W-1:0]           out_rd_valid,
    output logic [FETCH_W*PAYLOAD_W-1:0] out_payload,
    input  logic [COMMIT_W-1:0]          commit_en,
    input  logic [COMMIT_W*AW-1:0]       commit_arch_rd,
    input  logic [COMMIT_W*PW-1:0]       commit_prd,
    input  logic [COMMIT_W*PW-1:0]       commit_prd_old,
    input  logic                         flush,
    output logic [PW:0]                  free_count
);
    localparam int CW = PW + 1;

    generate
        if (PHYS_REGS < ARCH_REGS + FETCH_W) begin : g_cfg_check
            $error("rename_unit_ckpt: PHYS_REGS must be at least ARCH_REGS + FETCH_W");
        end
    endgenerate

    logic [PW-1:0]              map_r      [ARCH_REGS];
    logic [PW-1:0]              map_next_s [ARCH_REGS];
    logic [PW-1:0]              cmt_r      [ARCH_REGS];
    logic [PW-1:0]              cmt_next_s [ARCH_REGS];
    logic [PHYS_REGS-1:0]       free_mask_r;
    logic [PHYS_REGS-1:0]       free_next_s;
    logic [CW-1:0]              free_count_r;
    logic [CW-1:0]              free_count_next_s;
    logic [CW-1:0]              need_cnt_s;
    logic [FETCH_W-1:0]         need_s;
    logic                       in_ready_s;
    logic                       fire_s;
    logic [PW-1:0]              prd_s     [FETCH_W];
    logic [PW-1:0]              prs1_s    [FETCH_W];
    logic [PW-1:0]              prs2_s    [FETCH_W];
    logic [PW-1:0]              prd_old_s [FETCH_W];
    logic [FETCH_W-1:0]         out_valid_r;
    logic [FETCH_W-1:0]         out_rd_valid_r;
    logic [FETCH_W*PW-1:0]      out_prs1_r;
    logic [FETCH_W*PW-1:0]      out_prs2_r;
    logic [FETCH_W*PW-1:0]      out_prd_r;
    logic [FETCH_W*PW-1:0]      out_prd_old_r;
    logic [FETCH_W*PAYLOAD_W-1:0] out_payload_r;

    // Destination demand of the group and the all-or-nothing acceptance decision
    always_comb begin
        need_cnt_s = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            need_s[i]  = in_valid[i] && in_rd_valid[i] && (in_rd[i*AW +: AW] != '0);
            need_cnt_s = need_cnt_s + CW'(need_s[i]);
        end
        in_ready_s = !flush && ((out_valid_r == '0) || out_ready) && (free_count_r >= need_cnt_s);
        fire_s     = (|in_valid) && in_ready_s;
    end

    // Per-lane allocation (k-th needing lane takes k-th lowest free reg) and source lookup with bypass
    always_comb begin
        logic [PHYS_REGS-1:0] avail_v;
        logic [PW-1:0]        cand_v;
        logic [AW-1:0]        rs1_v;
        logic [AW-1:0]        rs2_v;
        logic [AW-1:0]        rd_v;
        avail_v = free_mask_r;
        for (int i = 0; i < FETCH_W; i++) begin
            cand_v = '0;
            for (int p = PHYS_REGS - 1; p > 0; p--) begin
                cand_v = avail_v[p] ? PW'(p) : cand_v;
            end
            prd_s[i]          = need_s[i] ? cand_v : '0;
            avail_v[prd_s[i]] = avail_v[prd_s[i]] & ~need_s[i];

            rs1_v        = in_rs1[i*AW +: AW];
            rs2_v        = in_rs2[i*AW +: AW];
            rd_v         = in_rd[i*AW +: AW];
            prs1_s[i]    = map_r[rs1_v];
            prs2_s[i]    = map_r[rs2_v];
            prd_old_s[i] = map_r[rd_v];
            // Ascending scan so the youngest older writer overrides earlier ones
            for (int j = 0; j < i; j++) begin
                prs1_s[i]    = (need_s[j] && (in_rd[j*AW +: AW] == rs1_v)) ? prd_s[j] : prs1_s[i];
                prs2_s[i]    = (need_s[j] && (in_rd[j*AW +: AW] == rs2_v)) ? prd_s[j] : prs2_s[i];
                prd_old_s[i] = (need_s[j] && (in_rd[j*AW +: AW] == rd_v))  ? prd_s[j] : prd_old_s[i];
            end
            prs1_s[i]    = (in_valid[i] && in_rs1_valid[i] && (rs1_v != '0)) ? prs1_s[i] : '0;
            prs2_s[i]    = (in_valid[i] && in_rs2_valid[i] && (rs2_v != '0)) ? prs2_s[i] : '0;
            prd_old_s[i] = need_s[i] ? prd_old_s[i] : '0;
        end
    end

    // Next committed map, speculative map and free list; flush overrides speculative state
    always_comb begin
        logic [PHYS_REGS-1:0] flush_free_v;
        logic                 rel_v;
        logic [AW-1:0]        arch_v;
        logic [PW-1:0]        old_v;
        cmt_next_s  = cmt_r;
        free_next_s = free_mask_r;
        for (int c = 0; c < COMMIT_W; c++) begin
            arch_v             = commit_arch_rd[c*AW +: AW];
            old_v              = commit_prd_old[c*PW +: PW];
            rel_v              = commit_en[c] && (arch_v != '0);
            cmt_next_s[arch_v] = rel_v ? commit_prd[c*PW +: PW] : cmt_next_s[arch_v];
            free_next_s[old_v] = free_next_s[old_v] | (rel_v && (old_v != '0));
        end
        map_next_s = map_r;
        for (int i = 0; i < FETCH_W; i++) begin
            free_next_s[prd_s[i]] = free_next_s[prd_s[i]] & ~(fire_s && need_s[i]);
            map_next_s[in_rd[i*AW +: AW]] = (fire_s && need_s[i]) ? prd_s[i]
                                                                  : map_next_s[in_rd[i*AW +: AW]];
        end
        // Everything not held by the committed map is reclaimable on flush
        flush_free_v = '1;
        for (int a = 0; a < ARCH_REGS; a++) begin
            flush_free_v[cmt_next_s[a]] = 1'b0;
            map_next_s[a]               = flush ? cmt_next_s[a] : map_next_s[a];
        end
        free_next_s       = flush ? flush_free_v : free_next_s;
        free_count_next_s = '0;
        for (int p = 0; p < PHYS_REGS; p++) begin
            free_count_next_s = free_count_next_s + CW'(free_next_s[p]);
        end
    end

    // Rename state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int a = 0; a < ARCH_REGS; a++) begin
                map_r[a] <= PW'(a);
                cmt_r[a] <= PW'(a);
            end
            for (int p = 0; p < PHYS_REGS; p++) begin
                free_mask_r[p] <= (p >= ARCH_REGS);
            end
            free_count_r <= CW'(PHYS_REGS - ARCH_REGS);
        end else begin
            map_r        <= map_next_s;
            cmt_r        <= cmt_next_s;
            free_mask_r  <= free_next_s;
            free_count_r <= free_count_next_s;
        end
    end

    // Dispatch-side output register; holds while stalled by out_ready
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r    <= '0;
            out_rd_valid_r <= '0;
            out_prs1_r     <= '0;
            out_prs2_r     <= '0;
            out_prd_r      <= '0;
            out_prd_old_r  <= '0;
            out_payload_r  <= '0;
        end else if (flush) begin
            out_valid_r <= '0;
        end else if (fire_s) begin
            out_valid_r    <= in_valid;
            out_rd_valid_r <= need_s;
            for (int i = 0; i < FETCH_W; i++) begin
                out_prs1_r[i*PW +: PW]    <= prs1_s[i];
                out_prs2_r[i*PW +: PW]    <= prs2_s[i];
                out_prd_r[i*PW +: PW]     <= prd_s[i];
                out_prd_old_r[i*PW +: PW] <= prd_old_s[i];
                out_payload_r[i*PAYLOAD_W +: PAYLOAD_W] <=
                    in_valid[i] ? in_payload[i*PAYLOAD_W +: PAYLOAD_W] : '0;
            end
        end else if (out_ready) begin
            out_valid_r <= '0;
        end
    end

    assign in_ready     = in_ready_s;
    assign out_valid    = out_valid_r;
    assign out_rd_valid = out_rd_valid_r;
    assign out_prs1     = out_prs1_r;
    assign out_prs2     = out_prs2_r;
    assign out_prd      = out_prd_r;
    assign out_prd_old  = out_prd_old_r;
    assign out_payload  = out_payload_r;
    assign free_count   = free_count_r;

endmodule

// File: tb/tb_rename_unit_ckpt.sv
// Scoreboard bench for rename_unit_ckpt: expected groups are queued at drive time
// and compared when the registered output appears one cycle later.
module tb_rename_unit_ckpt;
    typedef logic [243:0] obs_t;

    logic          clk;
    logic          reset_n;
    logic [1:0]    in_valid, in_rs1_valid, in_rs2_valid, in_rd_valid;
    logic          in_ready;
    logic [9:0]    in_rs1, in_rs2, in_rd;
    logic [191:0]  in_payload;
    logic [1:0]    out_valid;
    logic          out_ready;
    logic [11:0]   out_prs1, out_prs2, out_prd, out_prd_old;
    logic [1:0]    out_rd_valid;
    logic [191:0]  out_payload;
    logic [1:0]    commit_en;
    logic [9:0]    commit_arch_rd;
    logic [11:0]   commit_prd, commit_prd_old;
    logic          flush;
    logic [6:0]    free_count;

    obs_t sb_q[$];
    obs_t exp_v;
    obs_t hold_v;
    int   total = 0;
    int   bad   = 0;

    rename_unit_ckpt dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rs1_valid(in_rs1_valid), .in_rs2_valid(in_rs2_valid),
        .in_rd(in_rd), .in_rd_valid(in_rd_valid), .in_payload(in_payload),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_prs1(out_prs1), .out_prs2(out_prs2),
        .out_prd(out_prd), .out_prd_old(out_prd_old),
        .out_rd_valid(out_rd_valid), .out_payload(out_payload),
        .commit_en(commit_en), .commit_arch_rd(commit_arch_rd),
        .commit_prd(commit_prd), .commit_prd_old(commit_prd_old),
        .flush(flush), .free_count(free_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic obs_t obs();
        return {out_valid, out_prd, out_prd_old, out_prs1, out_prs2, out_rd_valid, out_payload};
    endfunction

    task automatic clear_inputs();
        in_valid = '0; in_rs1_valid = '0; in_rs2_valid = '0; in_rd_valid = '0;
        in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_payload = '0;
        commit_en = '0; commit_arch_rd = '0; commit_prd = '0; commit_prd_old = '0;
        flush = 1'b0;
    endtask

    task automatic set_lane(input int l, input logic [4:0] rd, input logic rdv,
                            input logic [4:0] rs1, input logic rs1v,
                            input logic [4:0] rs2, input logic rs2v);
        in_valid[l] = 1'b1;
        in_rd[l*5 +: 5] = rd;   in_rd_valid[l] = rdv;
        in_rs1[l*5 +: 5] = rs1; in_rs1_valid[l] = rs1v;
        in_rs2[l*5 +: 5] = rs2; in_rs2_valid[l] = rs2v;
        in_payload[l*96 +: 96] = {$urandom, $urandom, $urandom};
    endtask

    task automatic push_exp(input logic [1:0] v, input logic [11:0] prd, input logic [11:0] old,
                            input logic [11:0] p1, input logic [11:0] p2, input logic [1:0] rdv);
        logic [191:0] pay;
        pay = in_payload;
        if (!v[0]) pay[95:0] = '0;
        if (!v[1]) pay[191:96] = '0;
        sb_q.push_back({v, prd, old, p1, p2, rdv, pay});
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        out_ready = 1'b1;
        clear_inputs();
        sb_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_inputs();
        out_ready = 1'b1;
        #1;
        total++;
        if (obs() !== '0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", obs()); end
        total++;
        if (free_count !== 7'd16) begin bad++; $display("FAIL reset_free_count got=%0d exp=16", free_count); end
        do_reset();
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic();
        do_reset();
        set_lane(0, 5'd5, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1);
        set_lane(1, 5'd6, 1'b1, 5'd5, 1'b1, 5'd6, 1'b0);
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_ready got=%b exp=1", in_ready); end
        push_exp(2'b11, {6'd33, 6'd32}, {6'd6, 6'd5}, {6'd32, 6'd0}, {6'd0, 6'd9}, 2'b11);
        @(negedge clk);
        clear_inputs();
        total++;
        if (sb_q.size() == 0) begin bad++; $display("FAIL basic_out got=%h exp=queue_entry", obs()); end
        else begin
            exp_v = sb_q.pop_front();
            if (obs() !== exp_v) begin bad++; $display("FAIL basic_out got=%h exp=%h", obs(), exp_v); end
        end
        total++;
        if (free_count !== 7'd14) begin bad++; $display("FAIL basic_free got=%0d exp=14", free_count); end
    endtask

    task automatic test_bypass();
        do_reset();
        set_lane(0, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        set_lane(1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0);
        push_exp(2'b11, {6'd33, 6'd32}, {6'd32, 6'd7}, {6'd32, 6'd0}, 12'd0, 2'b11);
        @(negedge clk);
        clear_inputs();
        set_lane(0, 5'd0, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1);
        push_exp(2'b01, 12'd0, 12'd0, {6'd0, 6'd33}, {6'd0, 6'd33}, 2'b00);
        total++;
        if (sb_q.size() == 0) begin bad++; $display("FAIL bypass_group got=%h exp=queue_entry", obs()); end
        else begin
            exp_v = sb_q.pop_front();
            if (obs() !== exp_v) begin bad++; $display("FAIL bypass_group got=%h exp=%h", obs(), exp_v); end
        end
        @(negedge clk);
        clear_inputs();
        total++;
        if (sb_q.size() == 0) begin bad++; $display("FAIL bypass_lookup got=%h exp=queue_entry", obs()); end
        else begin
            exp_v = sb_q.pop_front();
            if (obs() !== exp_v) begin bad++; $display("FAIL bypass_lookup got=%h exp=%h", obs(), exp_v); end
        end
        total++;
        if (free_count !== 7'd14) begin bad++; $display("FAIL bypass_free got=%0d exp=14", free_count); end
    endtask

    task automatic test_free_exhaust();
        do_reset();
        for (int g = 0; g < 8; g++) begin
            clear_inputs();
            set_lane(0, 5'(2*g + 1), 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
            set_lane(1, 5'(2*g + 2), 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
            push_exp(2'b11, {6'(33 + 2*g), 6'(32 + 2*g)}, {6'(2*g + 2), 6'(2*g + 1)}, 12'd0, 12'd0, 2'b11);
            @(negedge clk);
            total++;
            if (sb_q.size() == 0) begin bad++; $display("FAIL exhaust_group got=%h exp=queue_entry", obs()); end
            else begin
                exp_v = sb_q.pop_front();
                if (obs() !== exp_v) begin bad++; $display("FAIL exhaust_group g=%0d got=%h exp=%h", g, obs(), exp_v); end
            end
        end
        clear_inputs();
        total++;
        if (free_count !== 7'd0) begin bad++; $display("FAIL exhaust_empty got=%0d exp=0", free_count); end
        set_lane(0, 5'd20, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        commit_en = 2'b01; commit_arch_rd = {5'd0, 5'd5};
        commit_prd = {6'd0, 6'd36}; commit_prd_old = {6'd0, 6'd5};
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL exhaust_stall1 got=%b exp=0", in_ready); end
        @(negedge clk);
        clear_inputs();
        total++;
        if (free_count !== 7'd1) begin bad++; $display("FAIL exhaust_release got=%0d exp=1", free_count); end
        set_lane(0, 5'd21, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        set_lane(1, 5'd22, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL exhaust_stall2 got=%b exp=0", in_ready); end
        @(negedge clk);
        clear_inputs();
        set_lane(0, 5'd20, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL exhaust_one got=%b exp=1", in_ready); end
        push_exp(2'b01, {6'd0, 6'd5}, {6'd0, 6'd20}, 12'd0, 12'd0, 2'b01);
        @(negedge clk);
        clear_inputs();
        total++;
        if (sb_q.size() == 0) begin bad++; $display("FAIL exhaust_realloc got=%h exp=queue_entry", obs()); end
        else begin
            exp_v = sb_q.pop_front();
            if (obs() !== exp_v) begin bad++; $display("FAIL exhaust_realloc got=%h exp=%h", obs(), exp_v); end
        end
        total++;
        if (free_count !== 7'd0) begin bad++; $display("FAIL exhaust_final got=%0d exp=0", free_count); end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        set_lane(0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        set_lane(1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        push_exp(2'b11, {6'd33, 6'd32}, {6'd6, 6'd5}, 12'd0, 12'd0, 2'b11);
        @(negedge clk);
        clear_inputs();
        total++;
        hold_v = '0;
        if (sb_q.size() == 0) begin bad++; $display("FAIL bp_first got=%h exp=queue_entry", obs()); end
        else begin
            hold_v = sb_q.pop_front();
            if (obs() !== hold_v) begin bad++; $display("FAIL bp_first got=%h exp=%h", obs(), hold_v); end
        end
        set_lane(0, 5'd7, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%b exp=0", in_ready); end
        @(negedge clk);
        total++;
        if (obs() !== hold_v) begin bad++; $display("FAIL bp_hold got=%h exp=%h", obs(), hold_v); end
        total++;
        if (free_count !== 7'd14) begin bad++; $display("FAIL bp_free got=%0d exp=14", free_count); end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b exp=1", in_ready); end
        push_exp(2'b01, {6'd0, 6'd34}, {6'd0, 6'd7}, {6'd0, 6'd32}, 12'd0, 2'b01);
        @(negedge clk);
        clear_inputs();
        total++;
        if (sb_q.size() == 0) begin bad++; $display("FAIL bp_next got=%h exp=queue_entry", obs()); end
        else begin
            exp_v = sb_q.pop_front();
            if (obs() !== exp_v) begin bad++; $display("FAIL bp_next got=%h exp=%h", obs(), exp_v); end
        end
    endtask

    task automatic test_flush(input logic with_commit);
        do_reset();
        out_ready = 1'b0;
        set_lane(0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        push_exp(2'b01, {6'd0, 6'd32}, {6'd0, 6'd5}, 12'd0, 12'd0, 2'b01);
        @(negedge clk);
        clear_inputs();
        total++;
        if (sb_q.size() == 0) begin bad++; $display("FAIL flush_alloc got=%h exp=queue_entry", obs()); end
        else begin
            exp_v = sb_q.pop_front();
            if (obs() !== exp_v) begin bad++; $display("FAIL flush_alloc got=%h exp=%h", obs(), exp_v); end
        end
        flush = 1'b1;
        if (with_commit) begin
            commit_en = 2'b01; commit_arch_rd = {5'd0, 5'd5};
            commit_prd = {6'd0, 6'd32}; commit_prd_old = {6'd0, 6'd5};
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b exp=0", in_ready); end
        @(negedge clk);
        clear_inputs();
        total++;
        if (out_valid !== 2'b00) begin bad++; $display("FAIL flush_valid got=%b exp=00", out_valid); end
        total++;
        if (free_count !== 7'd16) begin bad++; $display("FAIL flush_free got=%0d exp=16", free_count); end
        set_lane(0, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
        push_exp(2'b01, 12'd0, 12'd0, {6'd0, (with_commit ? 6'd32 : 6'd5)}, 12'd0, 2'b00);
        @(negedge clk);
        clear_inputs();
        total++;
        if (sb_q.size() == 0) begin bad++; $display("FAIL flush_lookup got=%h exp=queue_entry", obs()); end
        else begin
            exp_v = sb_q.pop_front();
            if (obs() !== exp_v) begin bad++; $display("FAIL flush_lookup c=%b got=%h exp=%h", with_commit, obs(), exp_v); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b0;
        set_lane(0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        push_exp(2'b01, {6'd0, 6'd32}, {6'd0, 6'd5}, 12'd0, 12'd0, 2'b01);
        @(negedge clk);
        clear_inputs();
        total++;
        if (sb_q.size() == 0) begin bad++; $display("FAIL areset_pre got=%h exp=queue_entry", obs()); end
        else begin
            exp_v = sb_q.pop_front();
            if (obs() !== exp_v) begin bad++; $display("FAIL areset_pre got=%h exp=%h", obs(), exp_v); end
        end
        set_lane(0, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (obs() !== '0) begin bad++; $display("FAIL areset_outputs got=%h exp=0", obs()); end
        total++;
        if (free_count !== 7'd16) begin bad++; $display("FAIL areset_free got=%0d exp=16", free_count); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL areset_ready got=%b exp=1", in_ready); end
        clear_inputs();
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        set_lane(0, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
        push_exp(2'b01, 12'd0, 12'd0, {6'd0, 6'd5}, 12'd0, 2'b00);
        @(negedge clk);
        clear_inputs();
        total++;
        if (sb_q.size() == 0) begin bad++; $display("FAIL areset_lookup got=%h exp=queue_entry", obs()); end
        else begin
            exp_v = sb_q.pop_front();
            if (obs() !== exp_v) begin bad++; $display("FAIL areset_lookup got=%h exp=%h", obs(), exp_v); end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        out_ready = 1'b1;
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_basic();
        test_bypass();
        test_free_exhaust();
        test_backpressure();
        test_flush(1'b0);
        test_flush(1'b1);
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
